// File: rtl/dcache_snoop_responder_pkg.sv
// Shared types and geometry for the dcache snoop responder.
// Address layout: {tag, set index, block word offset, byte offset}.
package dcache_snoop_responder_pkg;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 2;
    localparam int IDXW  = $clog2(SETS);
    localparam int TAGW  = 32 - IDXW - 3;
    localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB1    = 3'd1,
        ST_WB2    = 3'd2,
        ST_UPDATE = 3'd3,
        ST_INVAL  = 3'd4
    } snoop_state_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [IDXW-1:0] idx;
        logic            blkoff;
        logic [1:0]      bytoff;
    } dcache_addr_t;

    function automatic logic [31:0] block_base(input dcache_addr_t a);
        return {a.tag, a.idx, 3'b000};
    endfunction

endpackage

// File: rtl/dcache_snoop_responder_tag_match.sv
// Tag compare across all ways of the indexed set; the lowest hitting way
// wins so an (illegal) multi-way hit still resolves deterministically.
module snoop_tag_match
    import dcache_snoop_responder_pkg::*;
(
    input  logic [TAGW-1:0]      tag_i,
    input  logic [WAYS*TAGW-1:0] arr_tag_i,
    input  logic [WAYS-1:0]      arr_valid_i,
    input  logic [WAYS-1:0]      arr_dirty_i,
    output logic                 hit_o,
    output logic [WAYW-1:0]      hit_way_o,
    output logic                 hit_dirty_o
);

    always_comb begin
        hit_o       = 1'b0;
        hit_way_o   = '0;
        hit_dirty_o = 1'b0;
        // Walk from the top way down so the lowest match is the last writer.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (arr_valid_i[w] && (arr_tag_i[w*TAGW +: TAGW] == tag_i)) begin
                hit_o       = 1'b1;
                hit_way_o   = WAYW'(w);
                hit_dirty_o = arr_dirty_i[w];
            end
        end
    end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Cache-side snoop responder: answers coherence snoops, streams dirty blocks
// out for writeback, downgrades M->S or invalidates, and stalls the dcache FSM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | watching ccwait/ccinv against the live arrays
// WB1     | presenting captured word0 at block base
// WB2     | presenting captured word1 at block base + 4
// UPDATE  | clearing dirty (M->S) or valid (M->I) after the writeback
// INVAL   | clearing valid on a snoop invalidate of a non-written-back line
module dcache_snoop_responder
    import dcache_snoop_responder_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ccwait,
    input  logic                      ccinv,
    input  logic [31:0]               ccsnoopaddr,
    input  logic                      dwait,
    output logic                      ccwrite,
    output logic [31:0]               snp_daddr,
    output logic [31:0]               snp_dstore,
    output logic                      snp_active,
    output logic [IDXW-1:0]           arr_idx,
    input  logic [WAYS*TAGW-1:0]      arr_tag,
    input  logic [WAYS-1:0]           arr_valid,
    input  logic [WAYS-1:0]           arr_dirty,
    input  logic [WAYS*WORDS*32-1:0]  arr_data,
    output logic                      upd_en,
    output logic [IDXW-1:0]           upd_idx,
    output logic [WAYW-1:0]           upd_way,
    output logic                      upd_valid,
    output logic                      upd_dirty
);

    snoop_state_t    state_q;
    logic            inv_pend_q;
    logic [IDXW-1:0] idx_q;
    logic [WAYW-1:0] way_q;
    logic [31:0]     base_q;
    logic [31:0]     word0_q;
    logic [31:0]     word1_q;

    dcache_addr_t    snoop_addr;
    logic            hit;
    logic [WAYW-1:0] hit_way;
    logic            hit_dirty;
    logic            dirty_snoop;
    logic [31:0]     hit_word0;
    logic [31:0]     hit_word1;
    logic            offset_unused;

    assign snoop_addr    = dcache_addr_t'(ccsnoopaddr);
    assign offset_unused = ^{snoop_addr.blkoff, snoop_addr.bytoff};

    snoop_tag_match u_tag_match (
        .tag_i       (snoop_addr.tag),
        .arr_tag_i   (arr_tag),
        .arr_valid_i (arr_valid),
        .arr_dirty_i (arr_dirty),
        .hit_o       (hit),
        .hit_way_o   (hit_way),
        .hit_dirty_o (hit_dirty)
    );

    assign dirty_snoop = ccwait && hit && hit_dirty;
    assign hit_word0   = arr_data[(int'(hit_way) * WORDS + 0) * 32 +: 32];
    assign hit_word1   = arr_data[(int'(hit_way) * WORDS + 1) * 32 +: 32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            inv_pend_q <= 1'b0;
            idx_q      <= '0;
            way_q      <= '0;
            base_q     <= '0;
            word0_q    <= '0;
            word1_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dirty_snoop) begin
                        state_q    <= ST_WB1;
                        inv_pend_q <= ccinv;
                        idx_q      <= snoop_addr.idx;
                        way_q      <= hit_way;
                        base_q     <= block_base(snoop_addr);
                        word0_q    <= hit_word0;
                        word1_q    <= hit_word1;
                    end else if (ccinv && hit) begin
                        state_q <= ST_INVAL;
                        idx_q   <= snoop_addr.idx;
                        way_q   <= hit_way;
                    end
                end
                // Losing ccwait mid-stream abandons the writeback; the line stays M.
                ST_WB1: begin
                    if (!ccwait) begin
                        state_q <= ST_IDLE;
                    end else begin
                        inv_pend_q <= inv_pend_q | ccinv;
                        if (!dwait) state_q <= ST_WB2;
                    end
                end
                ST_WB2: begin
                    if (!ccwait) begin
                        state_q <= ST_IDLE;
                    end else begin
                        inv_pend_q <= inv_pend_q | ccinv;
                        if (!dwait) state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: state_q <= ST_IDLE;
                ST_INVAL:  state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ccwrite    = 1'b0;
        snp_daddr  = '0;
        snp_dstore = '0;
        snp_active = 1'b0;
        arr_idx    = '0;
        upd_en     = 1'b0;
        upd_idx    = '0;
        upd_way    = '0;
        upd_valid  = 1'b0;
        upd_dirty  = 1'b0;
        if (!RST) begin
            case (state_q)
                ST_IDLE: begin
                    arr_idx    = snoop_addr.idx;
                    ccwrite    = dirty_snoop;
                    snp_active = ccwait | ccinv;
                end
                ST_WB1: begin
                    arr_idx    = idx_q;
                    ccwrite    = 1'b1;
                    snp_active = 1'b1;
                    snp_daddr  = base_q;
                    snp_dstore = word0_q;
                end
                ST_WB2: begin
                    arr_idx    = idx_q;
                    ccwrite    = 1'b1;
                    snp_active = 1'b1;
                    snp_daddr  = base_q + 32'd4;
                    snp_dstore = word1_q;
                end
                ST_UPDATE: begin
                    arr_idx    = idx_q;
                    snp_active = 1'b1;
                    upd_en     = 1'b1;
                    upd_idx    = idx_q;
                    upd_way    = way_q;
                    upd_valid  = !inv_pend_q;
                end
                ST_INVAL: begin
                    arr_idx    = idx_q;
                    snp_active = 1'b1;
                    upd_en     = 1'b1;
                    upd_idx    = idx_q;
                    upd_way    = way_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Scoreboard bench for dcache_snoop_responder: a behavioural cache image
// feeds the arrays, expected beats/updates are queued at snoop time.
module tb_dcache_snoop_responder;
    import dcache_snoop_responder_pkg::*;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic                     ccwait, ccinv, dwait;
    logic [31:0]              ccsnoopaddr;
    logic                     ccwrite, snp_active;
    logic [31:0]              snp_daddr, snp_dstore;
    logic [IDXW-1:0]          arr_idx;
    logic [WAYS*TAGW-1:0]     arr_tag;
    logic [WAYS-1:0]          arr_valid, arr_dirty;
    logic [WAYS*WORDS*32-1:0] arr_data;
    logic                     upd_en, upd_valid, upd_dirty;
    logic [IDXW-1:0]          upd_idx;
    logic [WAYW-1:0]          upd_way;

    dcache_snoop_responder dut (
        .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .ccwrite(ccwrite),
        .snp_daddr(snp_daddr), .snp_dstore(snp_dstore), .snp_active(snp_active),
        .arr_idx(arr_idx), .arr_tag(arr_tag), .arr_valid(arr_valid),
        .arr_dirty(arr_dirty), .arr_data(arr_data), .upd_en(upd_en),
        .upd_idx(upd_idx), .upd_way(upd_way), .upd_valid(upd_valid),
        .upd_dirty(upd_dirty)
    );

    always #5 CLK = ~CLK;

    logic [TAGW-1:0] m_tag   [SETS][WAYS];
    bit              m_valid [SETS][WAYS];
    bit              m_dirty [SETS][WAYS];
    logic [31:0]     m_data  [SETS][WAYS][WORDS];

    always_comb begin
        arr_tag   = '0;
        arr_valid = '0;
        arr_dirty = '0;
        arr_data  = '0;
        for (int w = 0; w < WAYS; w++) begin
            arr_tag[w*TAGW +: TAGW] = m_tag[arr_idx][w];
            arr_valid[w]            = m_valid[arr_idx][w];
            arr_dirty[w]            = m_dirty[arr_idx][w];
            for (int k = 0; k < WORDS; k++)
                arr_data[(w*WORDS + k)*32 +: 32] = m_data[arr_idx][w][k];
        end
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;
    typedef struct { logic [IDXW-1:0] idx; logic [WAYW-1:0] way; logic valid; } upd_t;
    beat_t exp_beats[$];
    upd_t  exp_upd[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_wb"}, {snp_daddr, snp_dstore}, 64'd0);
        chk({name, "_ctl"}, 64'({ccwrite, snp_active, arr_idx, upd_en, upd_idx,
                                 upd_way, upd_valid, upd_dirty}), 64'd0);
    endtask

    function automatic void lookup(input logic [31:0] a, output bit hit, output int way);
        int s;
        s   = int'(a[IDXW+2:3]);
        hit = 1'b0;
        way = 0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == a[31:32-TAGW]) begin
                hit = 1'b1;
                way = w;
            end
    endfunction

    // Monitor: every accepted writeback word and every array update is checked
    // against the head of its queue.
    initial forever begin
        beat_t b;
        upd_t  u;
        @(negedge CLK);
        if (upd_en) begin
            if (exp_upd.size() == 0) begin
                total++; bad++;
                $display("FAIL upd_unexpected: got idx=%0d way=%0d valid=%0b, expected no update",
                         upd_idx, upd_way, upd_valid);
            end else begin
                u = exp_upd.pop_front();
                chk("upd_idx",   64'(upd_idx),   64'(u.idx));
                chk("upd_way",   64'(upd_way),   64'(u.way));
                chk("upd_valid", 64'(upd_valid), 64'(u.valid));
                chk("upd_dirty", 64'(upd_dirty), 64'd0);
            end
        end
        if (snp_daddr != 32'd0 && !dwait) begin
            if (exp_beats.size() == 0) begin
                total++; bad++;
                $display("FAIL beat_unexpected: got addr=%0h data=%0h, expected no beat",
                         snp_daddr, snp_dstore);
            end else begin
                b = exp_beats.pop_front();
                chk("wb_addr",   64'(snp_daddr),  64'(b.addr));
                chk("wb_data",   64'(snp_dstore), 64'(b.data));
                chk("wb_ccwrite", 64'(ccwrite),   64'd1);
                chk("wb_active", 64'(snp_active), 64'd1);
            end
        end
    end

    // abort_mode: 0 none, 1 ccwait drops in WB1, 2 ccwait drops in WB2, 3 RST in WB2
    // inv_mode:   0 no ccinv during writeback, 1 random, 2 raised in first WB2 cycle
    task automatic snoop(input logic [31:0] a, input bit cw, input bit ci,
                         input int waits, input int inv_mode, input int abort_mode);
        bit hit;
        int way;
        int s;
        bit inv;
        int nwords;
        int n;
        s = int'(a[IDXW+2:3]);
        lookup(a, hit, way);
        ccsnoopaddr = a; ccwait = cw; ccinv = ci; dwait = 1'b1;
        @(negedge CLK);
        chk("ccwrite_snoop", 64'(ccwrite), 64'(cw && hit && m_dirty[s][way]));
        chk("active_snoop",  64'(snp_active), 64'(cw | ci));
        chk("arr_idx",       64'(arr_idx), 64'(s));
        if (cw && hit && m_dirty[s][way]) begin
            inv    = ci;
            nwords = (abort_mode == 1) ? 0 : (abort_mode == 0) ? 2 : 1;
            for (int k = 0; k < nwords; k++)
                exp_beats.push_back('{addr: {a[31:3], 3'b000} + 32'(4*k), data: m_data[s][way][k]});
            @(posedge CLK); #1;
            for (int k = 0; k < 2; k++) begin
                if ((abort_mode == 1 && k == 0) || (abort_mode == 2 && k == 1)) begin
                    ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1;
                    @(posedge CLK); #1;
                    @(negedge CLK);
                    chk("abort_idle_active", 64'(snp_active), 64'd0);
                    chk("abort_idle_ccwrite", 64'(ccwrite), 64'd0);
                    @(posedge CLK); #1;
                    return;
                end
                if (abort_mode == 3 && k == 1) begin
                    RST = 1'b1; dwait = 1'b0;
                    @(negedge CLK);
                    chk_all_zero("rst_mid");
                    @(posedge CLK); #1;
                    RST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1;
                    @(negedge CLK);
                    chk("rst_idle_active", 64'(snp_active), 64'd0);
                    chk("rst_idle_upd", 64'(upd_en), 64'd0);
                    @(posedge CLK); #1;
                    return;
                end
                n = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
                for (int j = 0; j <= n; j++) begin
                    dwait = (j == n) ? 1'b0 : 1'b1;
                    ccinv = (inv_mode == 1) ? ($urandom_range(0, 3) == 0)
                                            : (inv_mode == 2 && k == 1 && j == 0);
                    @(negedge CLK);
                    inv |= ccinv;
                    @(posedge CLK); #1;
                end
            end
            ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1;
            exp_upd.push_back('{idx: IDXW'(s), way: WAYW'(way), valid: !inv});
            @(posedge CLK); #1;
            m_valid[s][way] = !inv;
            m_dirty[s][way] = 1'b0;
        end else if (ci && hit) begin
            exp_upd.push_back('{idx: IDXW'(s), way: WAYW'(way), valid: 1'b0});
            @(posedge CLK); #1;
            ccwait = 1'b0; ccinv = 1'b0;
            @(posedge CLK); #1;
            m_valid[s][way] = 1'b0;
            m_dirty[s][way] = 1'b0;
        end else begin
            @(posedge CLK); #1;
            ccwait = 1'b0; ccinv = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int s, w;
        for (int i = 0; i < SETS; i++)
            for (int j = 0; j < WAYS; j++) begin
                m_tag[i][j]   = TAGW'($urandom) | TAGW'(1);
                m_valid[i][j] = ($urandom_range(0, 3) != 0);
                m_dirty[i][j] = $urandom_range(0, 1) == 1;
                for (int k = 0; k < WORDS; k++) m_data[i][j][k] = $urandom;
            end

        RST = 1'b1;
        for (int c = 0; c < 2; c++) begin
            ccwait = 1'($urandom); ccinv = 1'($urandom); dwait = 1'($urandom);
            ccsnoopaddr = $urandom;
            @(negedge CLK);
            chk_all_zero("reset");
            @(posedge CLK); #1;
        end
        RST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1; ccsnoopaddr = 32'd0;
        @(negedge CLK);
        chk("post_reset_active", 64'(snp_active), 64'd0);
        @(posedge CLK); #1;

        // Directed: dirty hit in set 3 way 1 at 0x818
        m_tag[3][0] = TAGW'(32'h55); m_valid[3][0] = 1'b1; m_dirty[3][0] = 1'b0;
        m_tag[3][1] = TAGW'(32'h818 >> 6); m_valid[3][1] = 1'b1; m_dirty[3][1] = 1'b1;
        m_data[3][1][0] = 32'hAAAA_0001; m_data[3][1][1] = 32'hBBBB_0002;
        snoop(32'h0000_0818, 1'b1, 1'b0, 1, 0, 0);
        m_dirty[3][1] = 1'b1;
        snoop(32'h0000_0818, 1'b1, 1'b0, 1, 2, 0);
        m_valid[3][1] = 1'b1; m_dirty[3][1] = 1'b0;
        snoop(32'h0000_081C, 1'b0, 1'b1, 0, 0, 0);
        snoop(32'h0000_1818, 1'b1, 1'b1, 0, 0, 0);
        // Multi-way hit: way0 clean wins over dirty way1
        m_tag[5][0] = TAGW'(32'h123); m_tag[5][1] = TAGW'(32'h123);
        m_valid[5][0] = 1'b1; m_valid[5][1] = 1'b1;
        m_dirty[5][0] = 1'b0; m_dirty[5][1] = 1'b1;
        snoop({TAGW'(32'h123), 3'd5, 3'd4}, 1'b1, 1'b1, 0, 0, 0);
        // Aborts leave the line dirty; a later full writeback still happens
        m_valid[3][1] = 1'b1; m_dirty[3][1] = 1'b1;
        snoop(32'h0000_0818, 1'b1, 1'b0, 1, 0, 1);
        snoop(32'h0000_0818, 1'b1, 1'b0, 0, 0, 3);
        snoop(32'h0000_0818, 1'b1, 1'b0, 0, 0, 2);
        snoop(32'h0000_0818, 1'b1, 1'b0, 0, 0, 0);

        for (int t = 0; t < 300; t++) begin
            s = int'($urandom_range(0, SETS - 1));
            w = int'($urandom_range(0, WAYS - 1));
            if ($urandom_range(0, 3) != 0) a = {m_tag[s][w], IDXW'(s), 3'($urandom)};
            else                           a = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                m_valid[s][w] = 1'b1;
                m_dirty[s][w] = 1'b1;
            end
            snoop(a, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, -1, 1,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        @(negedge CLK);
        chk("beats_left", 64'(exp_beats.size()), 64'd0);
        chk("upds_left",  64'(exp_upd.size()),   64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
